rr_arbiter8: RTL
================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL provide parameter: MAX_HOLD, default 15, maximum consecutive cycles one requester may hold a grant (legal range 1..15).
REQ-002 SHALL provide port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: req  input  8  request lines, bit i = requester i, level-sensitive.
REQ-005 SHALL provide port: gnt  output  8  one-hot grant, all-zero when no grant.
REQ-006 SHALL provide port: gnt_idx  output  3  binary index of the granted requester, 3'd0 when no grant.
REQ-007 SHALL provide port: gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 SHALL provide port: timeout  output  1  one-cycle pulse on forced release.
REQ-009 SHALL drive all outputs from registers; no combinational path from req to any output.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (grant held).
REQ-011 SHALL hold a 3-bit round-robin pointer ptr giving the highest-priority requester index.
REQ-012 IDLE, req==0: SHALL remain IDLE with outputs at reset values.
REQ-013 IDLE, req!=0: SHALL select the first set bit scanning ptr, ptr+1, ..., ptr+7 modulo 8, and at the next edge SHALL assert gnt[sel], gnt_idx=sel, gnt_valid=1, enter BUSY, clear hold_cnt to 1.
REQ-014 Grant latency SHALL be exactly 1 cycle from the edge that samples req in IDLE to gnt visible.
REQ-015 BUSY: SHALL keep gnt, gnt_idx unchanged while req[gnt_idx]==1 and hold_cnt<MAX_HOLD, incrementing hold_cnt (4 bits, saturating at 15) each cycle.
REQ-016 BUSY, req[gnt_idx]==0 sampled: SHALL clear gnt, gnt_valid, gnt_idx at the next edge, return to IDLE, set ptr=(gnt_idx+1) mod 8, timeout stays 0.
REQ-017 BUSY, req[gnt_idx]==1 and hold_cnt==MAX_HOLD: SHALL release as in REQ-016 and assert timeout for exactly that one cycle.
REQ-018 Simultaneous drop of req[gnt_idx] and hold_cnt==MAX_HOLD SHALL be a normal release (timeout=0).
REQ-019 Every release SHALL produce at least one cycle with gnt==0 before any new grant (no back-to-back grants).
REQ-020 Changes on req bits other than gnt_idx during BUSY SHALL NOT affect grant or hold_cnt.
REQ-021 Pointer SHALL wrap: release of index 7 sets ptr=0.
REQ-022 gnt SHALL never have more than one bit set in any cycle.
REQ-023 Grant to a requester whose req is 0 in the sampling cycle SHALL never occur.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, state=IDLE, ptr=3'd0, hold_cnt=0.
REQ-025 Reset asserted during BUSY SHALL drop the grant without a timeout pulse and without pointer advance.
REQ-026 After rst_n deasserts, first arbitration SHALL occur on the first rising edge with rst_n high and req!=0.

Verification
REQ-027 Bench: after reset, req=8'hFF held -> grants in order 0,1,2,...,7,0 each lasting MAX_HOLD=15 cycles, timeout pulse at each release, one idle cycle between grants.
REQ-028 Bench: ptr=0, req=8'b0010_0100, requester 2 drops req after 3 granted cycles -> gnt=8'h04 for 3 cycles, 1 idle cycle, then gnt=8'h20, gnt_idx=5, timeout never asserted.
REQ-029 Bench: only req[7] toggled on/off 3 times -> gnt=8'h80 each time; ptr wraps to 0 after each release; req[0] raised afterward is granted ahead of req[7].
REQ-030 Bench: req[3] held, drop it in the cycle hold_cnt==MAX_HOLD -> release with timeout=0.
REQ-031 Bench: rst_n pulsed low mid-grant of index 4 -> outputs zero asynchronously before next clk edge; after release, req=8'h30 grants index 4 (ptr=0 scan).
REQ-032 Bench: all cycles check gnt one-hot-or-zero, gnt_valid==(gnt!=0), gnt_idx consistent with gnt.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Purpose: 8-way round-robin arbiter with a bounded grant hold time and a forced-release timeout pulse.
// Latency: a grant appears 1 cycle after the edge that samples req in IDLE; a release takes 1 cycle, then 1 idle cycle.
// Backpressure: none; req is level-sensitive and the grant holder keeps its grant by holding its req high (up to MAX_HOLD cycles).
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // The hold counter is 4 bits wide, so the limit is compared in that width.
    localparam logic [3:0] MAX_HOLD_C = MAX_HOLD[3:0];

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q,    state_d;
    logic [2:0] ptr_q,      ptr_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q,      gnt_d;
    logic [2:0] gnt_idx_q,  gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q,  timeout_d;

    // Arbitration candidates.
    logic       sel_found;
    logic [2:0] sel_idx;
    logic [2:0] cand;
    logic [7:0] sel_onehot;

    // Release conditions while BUSY.
    logic       owner_req;
    logic       hold_at_max;
    logic [3:0] hold_cnt_inc;

    // Scan ptr, ptr+1, ... ptr+7 (mod 8) and pick the first requester that is set.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // One-hot form of the selected index.
    always_comb begin
        sel_onehot = 8'h00;
        sel_onehot[sel_idx] = 1'b1;
    end

    // Owner status and a saturating increment for the hold counter.
    always_comb begin
        owner_req    = req[gnt_idx_q];
        hold_at_max  = (hold_cnt_q >= MAX_HOLD_C);
        hold_cnt_inc = (hold_cnt_q == 4'hF) ? 4'hF : hold_cnt_q + 4'd1;
    end

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = BUSY;
                    gnt_d       = sel_onehot;
                    gnt_idx_d   = sel_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 4'd1;
                end
            end
            BUSY: begin
                if (!owner_req || hold_at_max) begin
                    // A voluntary drop wins over the limit, so timeout only
                    // fires when the owner still wants the grant.
                    state_d     = IDLE;
                    gnt_d       = 8'h00;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 4'd0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    timeout_d   = owner_req;
                end else begin
                    hold_cnt_d  = hold_cnt_inc;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'h00;
                gnt_idx_d   = 3'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = 4'd0;
            end
        endcase
    end

    // State and output registers; reset clears everything, including the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 4'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
